// File: rtl/lbm_bram_arbiter.sv
// rtl/lbm_bram_arbiter.sv - solver/host arbiter for a single-port BRAM with pipelined read-tag return
// Define LBM_ARB_ROUND_ROBIN_EN to alternate contested grants; default build gives the solver fixed priority.
module lbm_bram_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_req,
  input  logic              s_we,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_wdata,
  output logic              s_gnt,
  output logic              s_rvalid,
  output logic [DATA_W-1:0] s_rdata,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              rd_pending
);

  logic              sel_s;
  logic              sel_h;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  // Stage k holds the tag of a read whose address was registered k cycles ago.
  logic [RD_LAT:0]   tag_v_q, tag_v_d;
  logic [RD_LAT:0]   tag_h_q, tag_h_d;

`ifdef LBM_ARB_ROUND_ROBIN_EN
  // Set when the host should win the next contested cycle.
  logic rr_host_q, rr_host_d;

  always_comb begin
    sel_s     = 1'b0;
    sel_h     = 1'b0;
    rr_host_d = rr_host_q;
    if (!rst) begin
      if (s_req && h_req) begin
        sel_s     = !rr_host_q;
        sel_h     = rr_host_q;
        rr_host_d = !rr_host_q;
      end else begin
        sel_s = s_req;
        sel_h = h_req;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_host_q <= 1'b0;
    end else begin
      rr_host_q <= rr_host_d;
    end
  end
`else
  always_comb begin
    sel_s = 1'b0;
    sel_h = 1'b0;
    if (!rst) begin
      sel_s = s_req;
      sel_h = h_req && !s_req;
    end
  end
`endif

  always_comb begin
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    if (sel_s) begin
      mem_we_d   = s_we;
      mem_addr_d = s_addr;
      mem_din_d  = s_wdata;
    end else if (sel_h) begin
      mem_we_d   = h_we;
      mem_addr_d = h_addr;
      mem_din_d  = h_wdata;
    end
    tag_v_d = {tag_v_q[RD_LAT-1:0], (sel_s && !s_we) || (sel_h && !h_we)};
    tag_h_d = {tag_h_q[RD_LAT-1:0], sel_h};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      mem_din_q  <= '0;
      tag_v_q    <= '0;
      tag_h_q    <= '0;
    end else begin
      mem_addr_q <= mem_addr_d;
      mem_we_q   <= mem_we_d;
      mem_din_q  <= mem_din_d;
      tag_v_q    <= tag_v_d;
      tag_h_q    <= tag_h_d;
    end
  end

  assign s_gnt      = sel_s;
  assign h_gnt      = sel_h;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_din    = mem_din_q;
  assign s_rvalid   = tag_v_q[RD_LAT] && !tag_h_q[RD_LAT];
  assign h_rvalid   = tag_v_q[RD_LAT] && tag_h_q[RD_LAT];
  assign s_rdata    = s_rvalid ? mem_dout : '0;
  assign h_rdata    = h_rvalid ? mem_dout : '0;
  assign rd_pending = |tag_v_q;

endmodule

// File: doc/lbm_bram_arbiter.md
LBM_BRAM_ARBITER -- requirements
Module: lbm_bram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, BRAM word-address width.
REQ-002 Parameter DATA_W, default 16, BRAM data width.
REQ-003 Parameter RD_LAT, default 2, BRAM read latency (cycles from registered address to valid mem_dout), range 1-4.
REQ-004 clk  in  1  clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 s_req  in  1  solver access request, held until granted.
REQ-007 s_we  in  1  solver write (1) / read (0).
REQ-008 s_addr  in  ADDR_W  solver address.
REQ-009 s_wdata  in  DATA_W  solver write data.
REQ-010 s_gnt  out  1  solver request accepted this cycle (combinational).
REQ-011 s_rvalid  out  1  solver read data valid.
REQ-012 s_rdata  out  DATA_W  solver read data.
REQ-013 h_req, h_we, h_addr, h_wdata, h_gnt, h_rvalid, h_rdata: host-readout port, same widths/meanings as solver port.
REQ-014 mem_addr  out  ADDR_W  registered BRAM address.
REQ-015 mem_we  out  1  registered BRAM write enable.
REQ-016 mem_din  out  DATA_W  registered BRAM write data.
REQ-017 mem_dout  in  DATA_W  BRAM read data.
REQ-018 rd_pending  out  1  any read in flight.

Function
REQ-019 At most one of s_gnt/h_gnt high per cycle; gnt only when corresponding req high.
REQ-020 Granted request at cycle N: mem_addr/mem_we/mem_din updated at edge N+1; mem_we = granted we.
REQ-021 Granted read at cycle N: matching rvalid high exactly one cycle at N+1+RD_LAT, rdata = mem_dout that cycle.
REQ-022 Read tags tracked in RD_LAT+1-stage shift register (valid bit + requester id); one read issuable per cycle, fully pipelined.
REQ-023 Back-to-back accesses serviced every cycle, no bubbles; order of BRAM operations equals grant order (write then read of same address returns new data).
REQ-024 No grant in a cycle: mem_we=0, mem_addr/mem_din hold previous value.
REQ-025 rdata of non-valid port driven 0.
REQ-026 Writes produce no rvalid.
REQ-027 rd_pending = OR of tag valid bits.
REQ-028 Single requester active: granted same cycle, no wait.
REQ-029 Request dropped before grant: no access, no state change.

Reset
REQ-030 Async rst clears: s_gnt/h_gnt=0 (no grant while rst), mem_we=0, mem_addr=0, mem_din=0, all tags invalid, s_rvalid/h_rvalid=0, rdata=0, rd_pending=0, round-robin pointer to solver-priority.
REQ-031 Reset mid-read: in-flight reads discarded, no rvalid after release.

Configuration
REQ-032 Macro LBM_ARB_ROUND_ROBIN_EN defined: on simultaneous s_req/h_req, grant goes to port not granted in most recent contested cycle; first contest after reset grants solver.
REQ-033 LBM_ARB_ROUND_ROBIN_EN undefined: fixed priority, solver always wins contests; host granted only when s_req low.

Verification
REQ-034 Solver read addr 0x005 (BRAM holds 0x1234), RD_LAT=2, h_req=0 -> s_gnt same cycle, s_rvalid exactly 3 cycles later, s_rdata=0x1234, h_rvalid=0.
REQ-035 Solver write 0x0A0=0xBEEF cycle N, solver read 0x0A0 cycle N+1 -> mem_we=1 at N+1, read returns 0xBEEF at N+4.
REQ-036 Both req high 6 cycles, all reads -> RR build: grants S,H,S,H,S,H, rvalids alternate with correct data; fixed build: 6 solver grants, h_gnt=0 until s_req drops.
REQ-037 Solver reads 8 consecutive addresses 0x000-0x007, one per cycle -> 8 consecutive s_rvalid pulses, data in address order, rd_pending high throughout.
REQ-038 Host read issued, rst pulsed 1 cycle after grant -> all outputs 0 during rst, no h_rvalid ever for that read, rd_pending=0.
